// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed N-digit common-anode 7-segment driver with frame-synchronous loads.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most-significant nonzero enabled digit.
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] DATA_IN,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   EN_IN,
    input  logic                    LOAD,
    output logic                    PENDING,
    output logic                    FRAME_TICK,
    output logic [7:0]              SSEG_CA,
    output logic [NUM_DIGITS-1:0]   SSEG_AN
);
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] sh_data, act_data;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_en, act_dp, act_en, lzb;
    logic                    slot_end, wrap, guard, blank;
    logic [3:0]              nib;

    assign slot_end = presc == PW'(SCAN_DIV - 1);
    assign wrap     = slot_end && idx == IW'(NUM_DIGITS - 1);
    assign guard    = GUARD_CYCLES > 0 && 32'(presc) < GUARD_CYCLES;
    assign nib      = act_data[4*idx +: 4];
    assign blank    = guard || !act_en[idx] || lzb[idx];

`ifdef LEADING_ZERO_BLANK_EN
    logic seen;
    // Scan from the top digit down; everything before the first nonzero enabled digit is a leading zero.
    always_comb begin
        seen = 1'b0;
        lzb  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen   = seen | (act_en[i] && act_data[4*i +: 4] != 4'd0);
            lzb[i] = i != 0 && !seen && !act_dp[i];
        end
    end
`else
    assign lzb = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc      <= '0;
            idx        <= '0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            PENDING    <= 1'b0;
            FRAME_TICK <= 1'b0;
            SSEG_AN    <= '1;
            SSEG_CA    <= 8'hFF;
        end else begin
            presc      <= slot_end ? '0 : presc + 1'b1;
            idx        <= slot_end ? (wrap ? '0 : idx + 1'b1) : idx;
            FRAME_TICK <= wrap;
            PENDING    <= !wrap && (LOAD || PENDING);
            if (LOAD) begin
                sh_data <= DATA_IN;
                sh_dp   <= DP_IN;
                sh_en   <= EN_IN;
            end
            // A load landing on the boundary bypasses the shadow so it shows in the very next frame.
            if (wrap && LOAD) begin
                act_data <= DATA_IN;
                act_dp   <= DP_IN;
                act_en   <= EN_IN;
            end else if (wrap && PENDING) begin
                act_data <= sh_data;
                act_dp   <= sh_dp;
                act_en   <= sh_en;
            end
            SSEG_AN <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
            SSEG_CA <= blank ? 8'hFF : {~act_dp[idx], SEG[nib][6:0]};
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: table-driven scoreboard bench for seg_scan_mux with 4 digits, SCAN_DIV=4, GUARD_CYCLES=1.
module tb_seg_scan_mux;
    localparam int N = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  lit_plain;
        logic [3:0]  lit_lzb;
        logic [31:0] ca;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en_in = '0;
    logic        pending, frame_tick;
    logic [7:0]  sseg_ca;
    logic [3:0]  sseg_an;
    int          tests = 0;
    int          fails = 0;
    vec_t        q[$];
    vec_t        vecs[7];
    vec_t        v_aaaa, v_5555, v_f00f;

    always #5 clk = ~clk;

    seg_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(4), .GUARD_CYCLES(1)) dut (
        .CLK(clk), .RST(rst), .DATA_IN(data_in), .DP_IN(dp_in), .EN_IN(en_in),
        .LOAD(load), .PENDING(pending), .FRAME_TICK(frame_tick),
        .SSEG_CA(sseg_ca), .SSEG_AN(sseg_an)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    task automatic chk_dark(input string nm);
        chk({nm, "_an"}, sseg_an, 4'hF);
        chk({nm, "_ca"}, sseg_ca, 8'hFF);
        chk({nm, "_pend"}, pending, 1'b0);
    endtask

    // Drive a one-cycle LOAD; the scoreboard keeps only the latest load awaiting commit.
    task automatic do_load(input vec_t v);
        data_in = v.data;
        dp_in   = v.dp;
        en_in   = v.en;
        load    = 1'b1;
        if (q.size() != 0) void'(q.pop_back());
        q.push_back(v);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_commit(input string nm);
        int n = 0;
        while (!frame_tick && n < 40) begin
            chk({nm, "_pend_hold"}, pending, 1'b1);
            @(negedge clk);
            n++;
        end
        chk({nm, "_tick_seen"}, frame_tick, 1'b1);
        chk({nm, "_pend_clr"}, pending, 1'b0);
    endtask

    // Called at the sample where FRAME_TICK is high; checks the 16 cycles of the next frame.
    task automatic check_frame(input string nm);
        vec_t       e;
        logic [3:0] lit, an_exp;
        logic [7:0] ca_exp;
        logic       on;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no expected frame queued", nm);
            return;
        end
        e   = q.pop_front();
        lit = LZB ? e.lit_lzb : e.lit_plain;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            on     = (c % 4 != 0) && lit[c / 4];
            an_exp = on ? ~(4'b0001 << (c / 4)) : 4'hF;
            ca_exp = on ? e.ca[8*(c / 4) +: 8] : 8'hFF;
            chk($sformatf("%s_an_c%0d", nm, c), sseg_an, an_exp);
            chk($sformatf("%s_ca_c%0d", nm, c), sseg_ca, ca_exp);
            chk($sformatf("%s_tick_c%0d", nm, c), frame_tick, c == 15);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // {data, dp, en, lit mask plain, lit mask with leading-zero blanking, CA per digit {d3,d2,d1,d0}}
        vecs[0] = '{16'h1234, 4'h0, 4'hF, 4'hF, 4'hF, 32'hF9A4B099};
        vecs[1] = '{16'h0008, 4'h1, 4'h5, 4'h5, 4'h1, 32'hFFC0FF00};
        vecs[2] = '{16'h0070, 4'h0, 4'hF, 4'hF, 4'h3, 32'hC0C0F8C0};
        vecs[3] = '{16'h0000, 4'h0, 4'hF, 4'hF, 4'h1, 32'hC0C0C0C0};
        vecs[4] = '{16'h0005, 4'h8, 4'hF, 4'hF, 4'h9, 32'h40C0C092};
        vecs[5] = '{16'hABCD, 4'h6, 4'hE, 4'hE, 4'hE, 32'h880346FF};
        vecs[6] = '{16'h9E6D, 4'h0, 4'hF, 4'hF, 4'hF, 32'h988682A1};
        v_aaaa  = '{16'hAAAA, 4'h0, 4'hF, 4'hF, 4'hF, 32'h88888888};
        v_5555  = '{16'h5555, 4'h0, 4'hF, 4'hF, 4'hF, 32'h92929292};
        v_f00f  = '{16'hF00F, 4'h0, 4'hF, 4'hF, 4'hF, 32'h8EC0C08E};

        repeat (3) begin
            @(negedge clk);
            chk_dark("rst");
            chk("rst_tick", frame_tick, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_dark("post_rst");
        chk("post_rst_tick", frame_tick, 1'b0);

        foreach (vecs[i]) begin
            repeat (2) @(negedge clk);
            do_load(vecs[i]);
            wait_commit($sformatf("v%0d", i));
            check_frame($sformatf("v%0d", i));
        end

        // Two loads inside one frame: only the second may ever be displayed.
        repeat (2) @(negedge clk);
        do_load(v_aaaa);
        repeat (3) @(negedge clk);
        do_load(v_5555);
        wait_commit("dbl");
        check_frame("dbl");

        // Load landing exactly on the frame boundary (16 cycles after the previous tick edge).
        repeat (15) @(negedge clk);
        do_load(v_f00f);
        chk("coinc_pend", pending, 1'b0);
        chk("coinc_tick", frame_tick, 1'b1);
        check_frame("coinc");

        // Reset mid-scan discards a pending load and clears the active registers.
        repeat (3) @(negedge clk);
        do_load(vecs[0]);
        chk("pend_before_rst", pending, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        chk_dark("mid_rst");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk_dark($sformatf("after_rst_c%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
